// File: rtl/param_banked_memory_if.sv
// Write/read bus for param_banked_memory: one write port with backpressure,
// one always-accepted read port with registered data.
interface param_banked_memory_if #(
   parameter int DW = 8,
   parameter int AW = 11
);
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] din;
   logic          wready;
   logic          ren;
   logic [AW-1:0] raddr;
   logic [DW-1:0] dout;
   logic          dvalid;

   modport master (
      output wen, waddr, din, ren, raddr,
      input  wready, dout, dvalid
   );

   modport slave (
      input  wen, waddr, din, ren, raddr,
      output wready, dout, dvalid
   );
endinterface

// File: rtl/param_banked_memory.sv
// Banked single-port RAM with a 1-entry write buffer absorbing same-bank read/write collisions.
// Optional macro BANK_CONFLICT_CNT_EN adds o_conflict_cnt (saturating count of buffered writes).
module param_banked_memory #(
   parameter int DW         = 8,
   parameter int BANKS      = 4,
   parameter int BANK_DEPTH = 512
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   param_banked_memory_if.slave  bus
`ifdef BANK_CONFLICT_CNT_EN
   ,
   output logic [15:0]           o_conflict_cnt
`endif
);

   localparam int AW = $clog2(BANKS * BANK_DEPTH);
   localparam int BW = $clog2(BANKS);
   localparam int WW = $clog2(BANK_DEPTH);

   logic                     r_buf_valid;
   logic [AW-1:0]            r_buf_addr;
   logic [DW-1:0]            r_buf_data;
   logic [DW-1:0]            r_dout;
   logic                     r_dvalid;

   logic [BW-1:0]            w_rd_bank;
   logic [WW-1:0]            w_rd_word;
   logic [BW-1:0]            w_wr_bank;
   logic [BW-1:0]            w_buf_bank;
   logic                     w_rd_act;
   logic                     w_wr_acc;
   logic                     w_collide;
   logic                     w_retire;
   logic [BW-1:0]            w_wsrc_bank;
   logic [WW-1:0]            w_wsrc_word;
   logic [DW-1:0]            w_wsrc_data;
   logic                     w_wsrc_en;
   logic [BANKS-1:0]         w_bank_we;
   logic [BANKS-1:0][DW-1:0] w_bank_rdata;
   logic [DW-1:0]            w_rdata;

   assign w_rd_bank  = bus.raddr[AW-1 -: BW];
   assign w_rd_word  = bus.raddr[WW-1:0];
   assign w_wr_bank  = bus.waddr[AW-1 -: BW];
   assign w_buf_bank = r_buf_addr[AW-1 -: BW];

   assign w_rd_act  = bus.ren && !i_rst;
   assign w_wr_acc  = bus.wen && !r_buf_valid && !i_rst;
   assign w_collide = w_wr_acc && w_rd_act && (w_wr_bank == w_rd_bank);
   assign w_retire  = r_buf_valid && !i_rst && !(w_rd_act && (w_buf_bank == w_rd_bank));

   // A retiring buffer and a newly accepted write are mutually exclusive, so one write source suffices.
   assign w_wsrc_bank = r_buf_valid ? w_buf_bank : w_wr_bank;
   assign w_wsrc_word = r_buf_valid ? r_buf_addr[WW-1:0] : bus.waddr[WW-1:0];
   assign w_wsrc_data = r_buf_valid ? r_buf_data : bus.din;
   assign w_wsrc_en   = w_retire || (w_wr_acc && !w_collide);

   always_comb begin
      w_bank_we = '0;
      for (int b = 0; b < BANKS; b++) begin
         w_bank_we[b] = w_wsrc_en && (w_wsrc_bank == BW'(b));
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [DW-1:0] r_mem [BANK_DEPTH];

      always_ff @(posedge i_clk) begin
         if (w_bank_we[b]) begin
            r_mem[w_wsrc_word] <= w_wsrc_data;
         end
      end

      assign w_bank_rdata[b] = r_mem[w_rd_word];
   end

   assign w_rdata = (r_buf_valid && (r_buf_addr == bus.raddr)) ? r_buf_data
                                                                : w_bank_rdata[w_rd_bank];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
      end else if (w_collide) begin
         r_buf_valid <= 1'b1;
         r_buf_addr  <= bus.waddr;
         r_buf_data  <= bus.din;
      end else if (w_retire) begin
         r_buf_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dout   <= '0;
         r_dvalid <= 1'b0;
      end else begin
         r_dvalid <= bus.ren;
         if (bus.ren) begin
            r_dout <= w_rdata;
         end
      end
   end

   assign bus.wready = !r_buf_valid;
   assign bus.dout   = r_dout;
   assign bus.dvalid = r_dvalid;

`ifdef BANK_CONFLICT_CNT_EN
   logic [15:0] r_conflict_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_conflict_cnt <= '0;
      end else if (w_collide && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_param_banked_memory.sv
// Bench for param_banked_memory: directed scenarios plus random traffic against a
// logical-memory reference (latest accepted write is visible to the next read).
module tb_param_banked_memory;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   param_banked_memory_if #(.DW(8), .AW(11)) bus ();

`ifdef BANK_CONFLICT_CNT_EN
   logic [15:0] cnt;
`endif

   param_banked_memory #(.DW(8), .BANKS(4), .BANK_DEPTH(512)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef BANK_CONFLICT_CNT_EN
      ,
      .o_conflict_cnt (cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference: contents as seen by reads, plus which bank holds a not-yet-retired write.
   logic [7:0]  lmem  [2048];
   bit          known [2048];
   bit          m_pend = 0;
   logic [1:0]  m_pbank;
   logic [10:0] m_paddr;
   logic [7:0]  m_pold;
   bit          m_poldk;
   logic [7:0]  m_dout = 8'h00;
   bit          m_doutk = 1;
   bit          m_dvalid = 0;
   logic [15:0] m_cnt = 16'h0000;

   task automatic check_outputs(input string tag);
      total++;
      if (bus.dvalid !== m_dvalid) begin
         bad++;
         $display("FAIL %s dvalid: got %b exp %b", tag, bus.dvalid, m_dvalid);
      end
      if (m_doutk) begin
         total++;
         if (bus.dout !== m_dout) begin
            bad++;
            $display("FAIL %s dout: got %h exp %h", tag, bus.dout, m_dout);
         end
      end
`ifdef BANK_CONFLICT_CNT_EN
      total++;
      if (cnt !== m_cnt) begin
         bad++;
         $display("FAIL %s conflict_cnt: got %h exp %h", tag, cnt, m_cnt);
      end
`endif
   endtask

   task automatic step(input string tag, input logic we, input logic [10:0] wa, input logic [7:0] wd,
                       input logic re, input logic [10:0] ra);
      logic [7:0] rv;
      bit         rk;
      @(negedge clk);
      bus.wen = we; bus.waddr = wa; bus.din = wd;
      bus.ren = re; bus.raddr = ra;
      #1;
      total++;
      if (bus.wready !== !m_pend) begin
         bad++;
         $display("FAIL %s wready: got %b exp %b", tag, bus.wready, !m_pend);
      end
      rv = lmem[ra];
      rk = known[ra];
      if (we && !m_pend) begin
         if (re && (wa[10:9] == ra[10:9])) begin
            m_pend  = 1;
            m_pbank = wa[10:9];
            m_paddr = wa;
            m_pold  = lmem[wa];
            m_poldk = known[wa];
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         lmem[wa]  = wd;
         known[wa] = 1;
      end else if (m_pend && !(re && (ra[10:9] == m_pbank))) begin
         m_pend = 0;
      end
      if (re) begin
         m_dout  = rv;
         m_doutk = rk;
      end
      m_dvalid = re;
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1;
         bus.wen = 1'b1; bus.waddr = 11'h7FE; bus.din = 8'hEE;
         bus.ren = 1'b1; bus.raddr = 11'h7FE;
         if (m_pend) begin
            lmem[m_paddr]  = m_pold;
            known[m_paddr] = m_poldk;
            m_pend = 0;
         end
         m_dout = 8'h00; m_doutk = 1; m_dvalid = 0; m_cnt = 16'h0000;
         @(posedge clk);
         #1;
         check_outputs("reset");
      end
      @(negedge clk);
      rst = 1'b0;
      bus.wen = 1'b0; bus.ren = 1'b0;
   endtask

   task automatic test_reset();
      reset_cycles(2);
      step("reset_idle", 0, 11'h000, 8'h00, 0, 11'h000);
   endtask

   task automatic test_basic();
      step("t1_write", 1, 11'h005, 8'hA5, 0, 11'h000);
      step("t1_read", 0, 11'h000, 8'h00, 1, 11'h005);
      total++;
      if (bus.dout !== 8'hA5) begin
         bad++;
         $display("FAIL t1_direct dout: got %h exp a5", bus.dout);
      end
      step("t1_idle", 0, 11'h000, 8'h00, 0, 11'h000);
   endtask

   task automatic test_diff_bank();
      step("t2_wr_rd", 1, 11'h600, 8'h3C, 1, 11'h005);
      step("t2_read", 0, 11'h000, 8'h00, 1, 11'h600);
      total++;
      if (bus.dout !== 8'h3C) begin
         bad++;
         $display("FAIL t2_direct dout: got %h exp 3c", bus.dout);
      end
   endtask

   task automatic test_collision();
      step("t3_collide", 1, 11'h010, 8'h77, 1, 11'h005);
      step("t3_retire", 0, 11'h000, 8'h00, 0, 11'h000);
      step("t3_ready", 0, 11'h000, 8'h00, 1, 11'h010);
      total++;
      if (bus.dout !== 8'h77) begin
         bad++;
         $display("FAIL t3_direct dout: got %h exp 77", bus.dout);
      end
   endtask

   task automatic test_forward();
      step("t4_collide", 1, 11'h020, 8'h11, 1, 11'h021);
      step("t4_fwd", 0, 11'h000, 8'h00, 1, 11'h020);
      total++;
      if (bus.dout !== 8'h11) begin
         bad++;
         $display("FAIL t4_direct dout: got %h exp 11", bus.dout);
      end
      step("t4_retire", 0, 11'h000, 8'h00, 0, 11'h000);
   endtask

   task automatic test_blocked();
      step("t5_prewrite", 1, 11'h400, 8'h42, 0, 11'h000);
      step("t5_collide", 1, 11'h030, 8'h55, 1, 11'h031);
      for (int i = 0; i < 5; i++) begin
         step("t5_blocked", 1, 11'h400, 8'h99, 1, 11'(i));
      end
      step("t5_retire", 0, 11'h000, 8'h00, 1, 11'h400);
      total++;
      if (bus.dout !== 8'h42) begin
         bad++;
         $display("FAIL t5_direct dout: got %h exp 42", bus.dout);
      end
      step("t5_read_buf", 0, 11'h000, 8'h00, 1, 11'h030);
   endtask

   task automatic test_reset_pending();
      step("t6_prewrite", 1, 11'h050, 8'hC7, 0, 11'h000);
      step("t6_collide", 1, 11'h050, 8'h3E, 1, 11'h051);
      reset_cycles(2);
      step("t6_read", 0, 11'h000, 8'h00, 1, 11'h050);
      total++;
      if (bus.dout !== 8'hC7) begin
         bad++;
         $display("FAIL t6_direct dout: got %h exp c7", bus.dout);
      end
      step("t6_unwritten", 0, 11'h000, 8'h00, 1, 11'h7FE);
   endtask

   task automatic test_random();
      logic [10:0] wa, ra;
      for (int i = 0; i < 400; i++) begin
         wa = {2'($urandom_range(0, 3)), 6'd0, 3'($urandom_range(0, 7))};
         ra = {2'($urandom_range(0, 3)), 6'd0, 3'($urandom_range(0, 7))};
         step("rand", 1'($urandom_range(0, 1)), wa, 8'($urandom), ($urandom_range(0, 9) < 7), ra);
      end
   endtask

   initial begin
      bus.wen = 1'b0; bus.waddr = '0; bus.din = '0;
      bus.ren = 1'b0; bus.raddr = '0;
      test_reset();
      test_basic();
      test_diff_bank();
      test_collision();
      test_forward();
      test_blocked();
      test_reset_pending();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
